// File: rtl/csa_resolve_pkg.sv
// rtl/csa_resolve_pkg.sv - shared widths and stage record for the carry-save resolver
package csa_resolve_pkg;

    localparam int CSA_DATA_W  = 64;
    localparam int CSA_CHUNK_W = 16;
    localparam int CSA_N_STG   = CSA_DATA_W / CSA_CHUNK_W;

    typedef struct packed {
        logic                  valid;
        logic [CSA_DATA_W-1:0] psum;
        logic                  carry;
        logic [CSA_DATA_W-1:0] s_rem;
        logic [CSA_DATA_W:0]   c_rem;
    } stg_t;

endpackage

// File: rtl/csa_slice_add.sv
// rtl/csa_slice_add.sv - combinational W-bit adder with carry-in and carry-out
module csa_slice_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_sum,
    output logic         o_co
);

    assign {o_co, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};

endmodule

// File: rtl/csa_resolve.sv
// rtl/csa_resolve.sv - pipelined carry-propagate resolution of a carry-save s/c pair
module csa_resolve
    import csa_resolve_pkg::*;
#(
    parameter int DATA_W  = CSA_DATA_W,
    parameter int CHUNK_W = CSA_CHUNK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] s,
    input  logic [DATA_W:0]   c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W+1:0] sum
);

    localparam int N_STG = DATA_W / CHUNK_W;

    logic w_adv;

    // One global enable: the whole pipe freezes when the last stage cannot drain.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < N_STG; k++) begin : g_stg
        stg_t               w_prev;
        stg_t               w_next;
        stg_t               r_q;
        logic [CHUNK_W-1:0] w_sum;
        logic               w_co;

        if (k == 0) begin : g_first
            assign w_prev = '{valid: in_valid, psum: '0, carry: 1'b0, s_rem: s, c_rem: c};
        end else begin : g_rest
            assign w_prev = g_stg[k-1].r_q;
        end

        csa_slice_add #(.W(CHUNK_W)) u_add (
            .i_a   (w_prev.s_rem[k*CHUNK_W +: CHUNK_W]),
            .i_b   (w_prev.c_rem[k*CHUNK_W +: CHUNK_W]),
            .i_ci  (w_prev.carry),
            .o_sum (w_sum),
            .o_co  (w_co)
        );

        always_comb begin
            w_next                            = w_prev;
            w_next.psum[k*CHUNK_W +: CHUNK_W] = w_sum;
            w_next.carry                      = w_co;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_adv) begin
                r_q <= w_next;
            end
        end
    end

    stg_t       w_last;
    logic [1:0] w_hi;
    logic       w_unused_bits;

    assign w_last        = g_stg[N_STG-1].r_q;
    assign w_hi          = 2'(w_last.c_rem[DATA_W]) + 2'(w_last.carry);
    assign out_valid     = w_last.valid;
    assign sum           = {w_hi, w_last.psum[DATA_W-1:0]};
    // Operand bits already consumed by earlier stages are dead at the output.
    assign w_unused_bits = &{1'b0, w_last.s_rem, w_last.c_rem[DATA_W-1:0]};

endmodule

// File: tb/tb_csa_resolve.sv
// tb/tb_csa_resolve.sv - directed and streamed checks of csa_resolve
module tb_csa_resolve;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] s;
    logic [64:0] c;
    logic        out_valid;
    logic        out_ready;
    logic [65:0] sum;

    int checks;
    int errors;

    csa_resolve #(.DATA_W(64), .CHUNK_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    typedef struct {
        logic [63:0] vs;
        logic [64:0] vc;
        logic [65:0] vsum;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Single isolated transaction: first-edge acceptance, 4-cycle latency, value.
    task automatic send_one(input logic [63:0] ts, input logic [64:0] tc,
                            input logic [65:0] texp, input string nm);
        int lat;
        bit seen;
        s         = ts;
        c         = tc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_accept"}, 66'(in_ready), 66'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
        end
        chk({nm, "_latency"}, 66'(lat), 66'(4));
        chk({nm, "_sum"}, sum, texp);
        @(posedge clk);
        #1;
    endtask

    task automatic gen(input int mode, output logic [63:0] gs, output logic [64:0] gc,
                       output logic [65:0] ge);
        logic [63:0] x, y, z;
        logic        b;
        if (mode == 0) begin
            b  = 1'($urandom_range(1));
            gs = {$urandom, $urandom};
            gc = {b, $urandom, $urandom};
            ge = {2'b00, gs} + {1'b0, gc};
        end else begin
            x  = {$urandom, $urandom};
            y  = {$urandom, $urandom};
            z  = {$urandom, $urandom};
            gs = x ^ y ^ z;
            gc = {(x & y) | (x & z) | (y & z), 1'b0};
            ge = {2'b00, x} + {2'b00, y} + {2'b00, z};
        end
    endtask

    // mode 0: continuous input with out_ready low for cycles 6..15; mode 1: random handshakes.
    task automatic run_stream(input int n, input int mode, input int budget);
        logic [63:0] ns;
        logic [64:0] nc;
        logic [65:0] ne;
        logic [65:0] q[$];
        logic [65:0] held;
        logic [65:0] expv;
        bit          have_held;
        int          sent, rcvd, cyc, unstable;
        bit          in_fire, out_fire;
        sent = 0; rcvd = 0; cyc = 0; unstable = 0; have_held = 1'b0; held = '0;
        gen(mode, ns, nc, ne);
        while (rcvd < n && cyc < budget) begin
            s = ns;
            c = nc;
            if (mode == 0) begin
                in_valid  = (sent < n);
                out_ready = !(cyc >= 6 && cyc <= 15);
            end else begin
                in_valid  = (sent < n) && ($urandom_range(3) != 0);
                out_ready = ($urandom_range(3) != 0);
            end
            @(negedge clk);
            if (mode == 0 && cyc == 12) begin
                chk("stall_in_ready", 66'(in_ready), 66'(0));
                chk("stall_out_valid", 66'(out_valid), 66'(1));
            end
            if (mode == 0 && cyc >= 6 && cyc <= 15 && out_valid) begin
                if (have_held && sum !== held) unstable++;
                held      = sum;
                have_held = 1'b1;
            end
            out_fire = out_valid && out_ready;
            in_fire  = in_valid && in_ready;
            if (out_fire) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 66'(out_valid), 66'(0));
                end else begin
                    expv = q.pop_front();
                    chk(mode == 0 ? "stall_stream_sum" : "csa_stream_sum", sum, expv);
                end
                rcvd++;
            end
            if (in_fire) begin
                q.push_back(ne);
                sent++;
                gen(mode, ns, nc, ne);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (mode == 0) chk("stall_sum_stable", 66'(unstable), 66'(0));
        chk(mode == 0 ? "stall_count" : "csa_count", 66'(rcvd), 66'(n));
    endtask

    initial begin
        int quiet;
        logic [63:0] ts;
        logic [64:0] tc;
        logic [65:0] te;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s         = '0;
        c         = '0;

        vecs[0] = '{64'h0, 65'h0, 66'h0, "zero"};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 65'h2, 66'h1_0000_0000_0000_0001, "ripple_all"};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE, 66'h2_FFFF_FFFF_FFFF_FFFD, "max"};
        vecs[3] = '{64'h1, 65'h0, 66'h1, "one"};
        vecs[4] = '{64'h0, 65'h1_0000_0000_0000_0000, 66'h1_0000_0000_0000_0000, "c_top"};
        vecs[5] = '{64'h0000_0000_0000_FFFF, 65'h1, 66'h0_0000_0000_0001_0000, "carry_stg1"};
        vecs[6] = '{64'h1234_5678_9ABC_DEF0, 65'h0_0FED_CBA9_8765_4321, 66'h0_2222_2222_2222_2211, "mixed"};
        vecs[7] = '{64'h8000_0000_0000_0000, 65'h0_8000_0000_0000_0000, 66'h1_0000_0000_0000_0000, "msb_carry"};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 66'(out_valid), 66'(0));
        chk("reset_in_ready", 66'(in_ready), 66'(1));
        chk("reset_sum", sum, 66'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send_one(vecs[i].vs, vecs[i].vc, vecs[i].vsum, vecs[i].name);
        end

        run_stream(20, 0, 200);

        // Three pairs in flight, output held back, then asynchronous reset.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            gen(0, ts, tc, te);
            s = ts;
            c = tc;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        quiet = 0;
        while (!out_valid && quiet < 8) begin
            @(negedge clk);
            quiet++;
        end
        chk("rst_fill_valid", 66'(out_valid), 66'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", 66'(out_valid), 66'(0));
        chk("rst_async_in_ready", 66'(in_ready), 66'(1));
        chk("rst_async_sum", sum, 66'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        send_one(64'h0000_0000_FFFF_0000, 65'h0_0000_0001_0001_0000, 66'h0_0000_0002_0000_0000, "post_rst");
        quiet     = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        chk("post_rst_no_stale", 66'(quiet), 66'(0));
        @(posedge clk);
        #1;

        run_stream(10000, 1, 60000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
